// File: rtl/kernel_bank_if.sv
// rtl/kernel_bank_if.sv - host load stream, frame select and active-kernel outputs of kernel_bank
interface kernel_bank_if #(
  parameter int KERNEL_NUM_ELEMENTS = 9,
  parameter int DATA_KERNEL_WIDTH   = 8,
  parameter int NUM_SLOTS           = 8,
  parameter int SHIFT_WIDTH         = 4,
  parameter int ADDR_W              = $clog2(NUM_SLOTS)
);
  logic [ADDR_W-1:0]                   i_kernel_address;
  logic                                i_frame_start;
  logic                                i_load_start;
  logic [ADDR_W-1:0]                   i_load_slot;
  logic [SHIFT_WIDTH-1:0]              i_load_shift;
  logic                                i_load_abort;
  logic                                i_coef_valid;
  logic signed [DATA_KERNEL_WIDTH-1:0] i_coef_data;
  logic                                o_coef_ready;
  logic                                o_load_busy;
  logic                                o_load_done;
  logic                                o_load_error;
  logic signed [DATA_KERNEL_WIDTH-1:0] o_kernel [KERNEL_NUM_ELEMENTS];
  logic [SHIFT_WIDTH-1:0]              o_shift;
  logic [ADDR_W-1:0]                   o_active_slot;

  modport master (
    output i_kernel_address, i_frame_start, i_load_start, i_load_slot, i_load_shift,
    output i_load_abort, i_coef_valid, i_coef_data,
    input  o_coef_ready, o_load_busy, o_load_done, o_load_error,
    input  o_kernel, o_shift, o_active_slot
  );

  modport slave (
    input  i_kernel_address, i_frame_start, i_load_start, i_load_slot, i_load_shift,
    input  i_load_abort, i_coef_valid, i_coef_data,
    output o_coef_ready, o_load_busy, o_load_done, o_load_error,
    output o_kernel, o_shift, o_active_slot
  );
endinterface

// File: rtl/kernel_bank.sv
// rtl/kernel_bank.sv - runtime-loadable convolution kernel bank, active kernel swapped only on frame start
// KERNEL_BANK_PRESET_EN: slots 0-7 reset to the built-in filter presets instead of identity.
module kernel_bank #(
  parameter int KERNEL_NUM_ELEMENTS = 9,
  parameter int DATA_KERNEL_WIDTH   = 8,
  parameter int NUM_SLOTS           = 8,
  parameter int SHIFT_WIDTH         = 4,
  parameter int ADDR_W              = $clog2(NUM_SLOTS)
) (
  input logic          i_clk,
  input logic          i_rst_n,
  kernel_bank_if.slave bus
);
  localparam int KNE    = KERNEL_NUM_ELEMENTS;
  localparam int DW     = DATA_KERNEL_WIDTH;
  localparam int CENTRE = KNE / 2;
  localparam int CNT_W  = $clog2(KNE + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(KNE - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;

`ifdef KERNEL_BANK_PRESET_EN
  function automatic logic signed [DW-1:0] reset_coef(input int slot, input int idx);
    int v;
    v = (idx == CENTRE) ? 1 : 0;
    case (slot)
      1: v = (idx == 4) ? 8 : -1;
      2: v = (idx == 4) ? 5 : ((idx % 2 == 1) ? -1 : 0);
      3: v = (idx == 4) ? 9 : -1;
      4: v = (idx == 4) ? -7 : 1;
      5: v = (idx == 4) ? 4 : ((idx % 2 == 1) ? 2 : 1);
      6: v = (idx < 2 || idx == 3) ? -1 : ((idx == 5 || idx > 6) ? 1 : 0);
      7: begin
        case (idx)
          0:       v = -2;
          1, 3:    v = -1;
          2, 6:    v = 0;
          8:       v = 2;
          default: v = 1;
        endcase
      end
      default: ;
    endcase
    return DW'(v);
  endfunction

  function automatic logic [SHIFT_WIDTH-1:0] reset_shift(input int slot);
    return (slot == 5) ? SHIFT_WIDTH'(4) : '0;
  endfunction
`else
  function automatic logic signed [DW-1:0] reset_coef(input int idx);
    return (idx == CENTRE) ? DW'(1) : '0;
  endfunction
`endif

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [ADDR_W-1:0]      slot_q;
  logic [SHIFT_WIDTH-1:0] ld_shift_q;
  logic signed [DW-1:0]   staging_q [KNE];
  logic                   ready_q, busy_q, done_q, error_q;

  logic signed [DW-1:0]   bank_q [NUM_SLOTS][KNE];
  logic [SHIFT_WIDTH-1:0] bank_shift_q [NUM_SLOTS];

  logic signed [DW-1:0]   kernel_q [KNE];
  logic [SHIFT_WIDTH-1:0] shift_q;
  logic [ADDR_W-1:0]      active_q;

  logic                   load_slot_ok;
  logic                   frame_addr_ok;
  logic [ADDR_W-1:0]      frame_slot;

  // Range checks only exist when the address field can express nonexistent slots.
  generate
    if ((1 << ADDR_W) > NUM_SLOTS) begin : g_partial
      localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_SLOTS);
      assign load_slot_ok  = {1'b0, bus.i_load_slot} < LIMIT;
      assign frame_addr_ok = {1'b0, bus.i_kernel_address} < LIMIT;
    end else begin : g_full
      assign load_slot_ok  = 1'b1;
      assign frame_addr_ok = 1'b1;
    end
  endgenerate

  assign frame_slot = frame_addr_ok ? bus.i_kernel_address : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      slot_q     <= '0;
      ld_shift_q <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      for (int e = 0; e < KNE; e++) staging_q[e] <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.i_load_start) begin
            if (load_slot_ok) begin
              state_q    <= S_LOAD;
              slot_q     <= bus.i_load_slot;
              ld_shift_q <= bus.i_load_shift;
              cnt_q      <= '0;
              ready_q    <= 1'b1;
              busy_q     <= 1'b1;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          // Abort wins over a coincident beat, including the final one.
          if (bus.i_load_abort) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (bus.i_coef_valid) begin
            staging_q[cnt_q] <= bus.i_coef_data;
            cnt_q            <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
              state_q <= S_COMMIT;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_COMMIT: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        for (int e = 0; e < KNE; e++) begin
`ifdef KERNEL_BANK_PRESET_EN
          bank_q[s][e] <= reset_coef(s, e);
`else
          bank_q[s][e] <= reset_coef(e);
`endif
        end
`ifdef KERNEL_BANK_PRESET_EN
        bank_shift_q[s] <= reset_shift(s);
`else
        bank_shift_q[s] <= '0;
`endif
      end
    end else if (state_q == S_COMMIT) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (ADDR_W'(s) == slot_q) begin
          for (int e = 0; e < KNE; e++) bank_q[s][e] <= staging_q[e];
          bank_shift_q[s] <= ld_shift_q;
        end
      end
    end
  end

  // Frame start coinciding with a commit to the same slot forwards the staged kernel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int e = 0; e < KNE; e++) kernel_q[e] <= (e == CENTRE) ? DW'(1) : '0;
      shift_q  <= '0;
      active_q <= '0;
    end else if (bus.i_frame_start) begin
      active_q <= frame_slot;
      if (state_q == S_COMMIT && slot_q == frame_slot) begin
        for (int e = 0; e < KNE; e++) kernel_q[e] <= staging_q[e];
        shift_q <= ld_shift_q;
      end else begin
        for (int e = 0; e < KNE; e++) kernel_q[e] <= bank_q[frame_slot][e];
        shift_q <= bank_shift_q[frame_slot];
      end
    end
  end

  assign bus.o_coef_ready  = ready_q;
  assign bus.o_load_busy   = busy_q;
  assign bus.o_load_done   = done_q;
  assign bus.o_load_error  = error_q;
  assign bus.o_kernel      = kernel_q;
  assign bus.o_shift       = shift_q;
  assign bus.o_active_slot = active_q;
endmodule
